clock_period_meter: RTL



---
 rtl/clock_meter_pkg.sv | 14 +
 rtl/sync_edge_detect.sv | 34 +++
 rtl/clock_period_meter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/clock_meter_pkg.sv
// clock_meter_pkg: FSM state type and counter constants shared by the clock period meter.
package clock_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS,
        DONE
    } meter_state_e;

    localparam int DEF_CNT_W = 16;
    localparam int CNT_MAX   = (1 << DEF_CNT_W) - 1;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop synchronizer for an asynchronous input plus an edge-detect flop,
// producing single-cycle rise and fall pulses in the clk_in domain.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], sig_in};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/clock_period_meter.sv
// clock_period_meter: single-shot measurement of a slow signal's period and high time in clk_in cycles.
// Define DUTY_MEASURE_EN to build the high-time path; without it high_time is tied to 0.
module clock_period_meter
    import clock_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_TOP = '1;

    meter_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             rise, fall, at_top;

    sync_edge_detect #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_in(clk_in),
        .reset (reset),
        .sig_in(sig_in),
        .rise  (rise),
        .fall  (fall)
    );

`ifdef DUTY_MEASURE_EN
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             fell_q, fell_d;
    assign high_time = high_time_q;
`else
    logic unused_fall;
    assign unused_fall = fall;
    assign high_time   = '0;
`endif

    assign at_top = (cnt_q == CNT_TOP);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        timeout  = 1'b0;
`ifdef DUTY_MEASURE_EN
        high_d      = high_q;
        high_time_d = high_time_q;
        fell_d      = fell_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (rise) begin
                    cnt_d   = CNT_W'(1);
                    state_d = MEAS;
`ifdef DUTY_MEASURE_EN
                    fell_d  = 1'b0;
`endif
                end else if (at_top) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MEAS: begin
                // A terminating rise beats saturation, so a full-scale period still completes.
                if (rise) begin
                    period_d = cnt_q;
                    state_d  = DONE;
`ifdef DUTY_MEASURE_EN
                    high_time_d = fell_q ? high_q : cnt_q;
`endif
                end else if (at_top) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef DUTY_MEASURE_EN
                    if (fall) begin
                        high_d = cnt_q;
                        fell_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
`ifdef DUTY_MEASURE_EN
            high_q      <= '0;
            high_time_q <= '0;
            fell_q      <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
`ifdef DUTY_MEASURE_EN
            high_q      <= high_d;
            high_time_q <= high_time_d;
            fell_q      <= fell_d;
`endif
        end
    end

    assign period = period_q;
    assign valid  = (state_q == DONE);
    assign busy   = (state_q == ARM) || (state_q == MEAS);

endmodule
